asm_volume_param: RTL and testbench

//  Parametrised volume-control FSM for the music player: steps a saturating level up/down on button

---
 rtl/asm_volume_param.sv | 203 ++++++++++++++++++++
 tb/tb_asm_volume_param.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asm_volume_param.sv
// asm_volume_param: saturating volume level with mute, two BCD display digits and a change pulse.
// Latency: action visible 2 clk after the edge that first samples a button high; mudou_volume lasts 1 clk.
// Backpressure: none; presses seen while an action is pending or a button is still held are dropped.
// Optional macro AUTO_REPEAT_EN: a steadily held up/down button repeats after HOLD_CYCLES, then every
// REPEAT_CYCLES (both must be >= 2 so the repeat spacing matches the parameter exactly).
module asm_volume_param #(
    parameter int MAX_VOL       = 10,
    parameter int STEP          = 1,
    parameter int RESET_VOL     = 0,
    parameter int HOLD_CYCLES   = 50,
    parameter int REPEAT_CYCLES = 20,
    localparam int W = $clog2(MAX_VOL + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         aumenta,
    input  logic         diminui,
    input  logic         mute,
    output logic [3:0]   volume1,
    output logic [3:0]   volume0,
    output logic [W-1:0] nivel,
    output logic         mudo,
    output logic         mudou_volume
);

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        EXECUTA = 2'd1,
        SOLTA   = 2'd2
    } state_t;

    localparam int         WX    = W + 1;
    localparam logic [W:0] MAX_X = WX'(MAX_VOL);
    localparam logic [W:0] STP_X = WX'(STEP);
    localparam logic [W-1:0] RST_LVL = W'(RESET_VOL);

    // Parameter sanity, caught at elaboration
    if (MAX_VOL < 1 || MAX_VOL > 99) begin : g_bad_max
        $error("asm_volume_param: MAX_VOL must be 1..99");
    end
    if (STEP < 1 || STEP > MAX_VOL) begin : g_bad_step
        $error("asm_volume_param: STEP must be 1..MAX_VOL");
    end
    if (RESET_VOL < 0 || RESET_VOL > MAX_VOL) begin : g_bad_rst
        $error("asm_volume_param: RESET_VOL must be 0..MAX_VOL");
    end
    if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_rpt
        $error("asm_volume_param: HOLD_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    // Button bit order: {mute, aumenta, diminui}
    logic [2:0]   btn_d, btn_q, hist_q;
    logic         press;
    logic         rpt_fire;
    logic         exec_en;
    state_t       state_q, state_d;
    logic [W-1:0] nivel_q, nivel_d;
    logic         mudo_q, mudo_d;
    logic         mudou_q, mudou_d;
    logic [W:0]   nivel_x;
    logic [W:0]   up_sum;
    logic [W-1:0] disp_q, disp_d;
    logic [6:0]   disp7;

    assign btn_d = {mute, aumenta, diminui};
    assign press = |(btn_q & ~hist_q);

    // Sample buttons once and keep one cycle of history; both start high so a button held through reset is ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q  <= 3'b111;
            hist_q <= 3'b111;
        end else begin
            btn_q  <= btn_d;
            hist_q <= btn_q;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int CMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_CYCLES - 2);
    localparam logic [CW-1:0] REP_LIM  = CW'(REPEAT_CYCLES - 2);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          rep_q, rep_d;
    logic          single_held;

    // Only one direction button, unchanged since last cycle, keeps the repeat timer alive
    assign single_held = ((btn_q == 3'b010) || (btn_q == 3'b001)) && (btn_q == hist_q);
    assign rpt_fire    = (state_q == SOLTA) && single_held &&
                         (cnt_q == (rep_q ? REP_LIM : HOLD_LIM));

    // Repeat timer: counts SOLTA cycles since the last action; first gap is HOLD, later gaps REPEAT
    always_comb begin
        cnt_d = '0;
        rep_d = rep_q;
        case (state_q)
            ESPERA:  rep_d = 1'b0;
            EXECUTA: rep_d = rep_q;
            SOLTA: begin
                if (!single_held) begin
                    rep_d = 1'b0;
                end else if (rpt_fire) begin
                    rep_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: rep_d = 1'b0;
        endcase
    end

    // Repeat timer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            rep_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            rep_q <= rep_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ESPERA;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one action per press, then wait for every button to be released
    always_comb begin
        state_d = state_q;
        case (state_q)
            ESPERA:  if (press) state_d = EXECUTA;
            EXECUTA: state_d = SOLTA;
            SOLTA: begin
                if (btn_q == 3'b000) begin
                    state_d = ESPERA;
                end else if (rpt_fire) begin
                    state_d = EXECUTA;
                end
            end
            default: state_d = ESPERA;
        endcase
    end

    // FSM outputs: the action strobe
    always_comb begin
        exec_en = (state_q == EXECUTA);
    end

    // Level/mute update: mute wins, up and down together cancel, arithmetic saturates in W+1 bits
    always_comb begin
        nivel_d = nivel_q;
        mudo_d  = mudo_q;
        nivel_x = {1'b0, nivel_q};
        up_sum  = nivel_x + STP_X;
        if (exec_en) begin
            if (btn_q[2]) begin
                mudo_d = ~mudo_q;
            end else if (btn_q[1] ^ btn_q[0]) begin
                mudo_d = 1'b0;
                if (btn_q[1]) begin
                    nivel_d = (up_sum > MAX_X) ? W'(MAX_X) : W'(up_sum);
                end else begin
                    nivel_d = (nivel_x >= STP_X) ? W'(nivel_x - STP_X) : '0;
                end
            end
        end
    end

    assign disp_q  = mudo_q ? '0 : nivel_q;
    assign disp_d  = mudo_d ? '0 : nivel_d;
    assign mudou_d = (disp_d != disp_q);

    // Level, mute and change-pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            nivel_q <= RST_LVL;
            mudo_q  <= 1'b0;
            mudou_q <= 1'b0;
        end else begin
            nivel_q <= nivel_d;
            mudo_q  <= mudo_d;
            mudou_q <= mudou_d;
        end
    end

    assign disp7        = 7'(disp_q);
    assign volume1      = 4'(disp7 / 7'd10);
    assign volume0      = 4'(disp7 % 7'd10);
    assign nivel        = nivel_q;
    assign mudo         = mudo_q;
    assign mudou_volume = mudou_q;

endmodule

// File: tb/tb_asm_volume_param.sv
`timescale 1ns/1ps
module tb_asm_volume_param;

    localparam int MAXV = 10;
    localparam int STP  = 1;
    localparam int RV   = 0;
    localparam int HOLD = 50;
    localparam int REP  = 20;
    localparam int W    = $clog2(MAXV + 1);
`ifdef AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam logic [2:0] B_UP = 3'b010;
    localparam logic [2:0] B_DN = 3'b001;
    localparam logic [2:0] B_MU = 3'b100;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         aumenta = 1'b0, diminui = 1'b0, mute = 1'b0;
    logic [3:0]   volume1, volume0;
    logic [W-1:0] nivel;
    logic         mudo, mudou_volume;

    logic         reset2 = 1'b1;
    logic         a2 = 1'b0, d2 = 1'b0, m2 = 1'b0;
    logic [3:0]   v1b, v0b;
    logic [4:0]   nivel2;
    logic         mudo2, pulse2;

    int checks = 0;
    int failures = 0;
    int pcnt = 0;
    int pcnt2 = 0;
    int p0;

    always #5 clk = ~clk;

    asm_volume_param #(
        .MAX_VOL(MAXV), .STEP(STP), .RESET_VOL(RV), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) u_dut (
        .clk(clk), .reset(reset), .aumenta(aumenta), .diminui(diminui), .mute(mute),
        .volume1(volume1), .volume0(volume0), .nivel(nivel), .mudo(mudo),
        .mudou_volume(mudou_volume)
    );

    asm_volume_param #(
        .MAX_VOL(20), .STEP(3), .RESET_VOL(18), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) u_dut2 (
        .clk(clk), .reset(reset2), .aumenta(a2), .diminui(d2), .mute(m2),
        .volume1(v1b), .volume0(v0b), .nivel(nivel2), .mudo(mudo2),
        .mudou_volume(pulse2)
    );

    // ---------------- behavioural model (event view: press -> action two edges later) ----------------
    int         m_lvl, m_dprev, m_stage, m_cyc = 0, m_next;
    bit         m_mudo, m_pulse, m_first, m_rep_en, m_valid = 1'b0;
    logic [2:0] m_prev, m_act, m_held;

    task model_apply();
        if (m_act[2]) begin
            m_mudo = !m_mudo;
        end else if (m_act[1] ^ m_act[0]) begin
            m_mudo = 1'b0;
            if (m_act[1]) m_lvl = (m_lvl + STP > MAXV) ? MAXV : m_lvl + STP;
            else          m_lvl = (m_lvl - STP < 0) ? 0 : m_lvl - STP;
        end
        m_held  = m_act;
        m_rep_en = (m_act == B_UP) || (m_act == B_DN);
        m_next  = m_cyc + (m_first ? HOLD : REP);
        m_first = 1'b0;
    endtask

    task model_step();
        logic [2:0] s;
        int disp;
        s = {mute, aumenta, diminui};
        m_cyc++;
        if (reset) begin
            m_lvl   = RV;
            m_mudo  = 1'b0;
            m_pulse = 1'b0;
            m_dprev = RV;
            m_prev  = 3'b111;
            m_stage = 0;
            m_valid = 1'b1;
        end else begin
            case (m_stage)
                1: begin m_act = s; m_stage = 2; end
                2: begin model_apply(); m_stage = 3; end
                3: begin
                    if (s == 3'b000) begin
                        m_stage = 0;
                    end else begin
                        if (s != m_held) m_rep_en = 1'b0;
                        if (AUTO && m_rep_en && (m_cyc + 1 == m_next)) begin
                            m_act = s;
                            m_stage = 2;
                        end
                    end
                end
                default: if ((s & ~m_prev) != 3'b000) begin m_stage = 1; m_first = 1'b1; end
            endcase
            m_prev  = s;
            disp    = m_mudo ? 0 : m_lvl;
            m_pulse = (disp != m_dprev);
            m_dprev = disp;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of the main DUT against the model
    initial forever begin
        @(negedge clk);
        if (m_valid) begin : cmp
            int ed;
            ed = m_mudo ? 0 : m_lvl;
            checks++;
            if (volume1 !== 4'(ed / 10) || volume0 !== 4'(ed % 10) || nivel !== W'(m_lvl) ||
                mudo !== m_mudo || mudou_volume !== m_pulse) begin
                failures++;
                $display("FAIL cycle %0d: got disp=%0d%0d nivel=%0d mudo=%0b pulse=%0b, need disp=%0d nivel=%0d mudo=%0b pulse=%0b",
                         m_cyc, volume1, volume0, nivel, mudo, mudou_volume, ed, m_lvl, m_mudo, m_pulse);
            end
        end
    end

    // Pulse counters
    initial forever begin
        @(negedge clk);
        if (mudou_volume === 1'b1) pcnt++;
        if (pulse2 === 1'b1) pcnt2++;
    end

    // ---------------- helpers ----------------
    function automatic int shown();
        return int'(volume1) * 10 + int'(volume0);
    endfunction

    function automatic int shown2();
        return int'(v1b) * 10 + int'(v0b);
    endfunction

    task chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d need %0d", name, got, exp);
        end
    endtask

    task press(input logic [2:0] b, input int n);
        @(negedge clk);
        {mute, aumenta, diminui} = b;
        repeat (n) @(negedge clk);
        {mute, aumenta, diminui} = 3'b000;
        repeat (6) @(negedge clk);
    endtask

    task press2(input logic [2:0] b);
        @(negedge clk);
        {m2, a2, d2} = b;
        repeat (30) @(negedge clk);
        {m2, a2, d2} = 3'b000;
        repeat (6) @(negedge clk);
    endtask

    task do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk("reset display", shown(), 0);
        chk("reset nivel", int'(nivel), 0);
        chk("reset mudo", int'(mudo), 0);
        chk("reset pulse", int'(mudou_volume), 0);
        reset = 1'b0;

        // 1: four up presses
        p0 = pcnt;
        for (int i = 1; i <= 4; i++) begin
            press(B_UP, 30);
            chk($sformatf("up press %0d", i), shown(), i);
        end
        chk("up pulses", pcnt - p0, 4);

        // 2: two down presses then reset
        press(B_DN, 30);
        chk("down to 3", shown(), 3);
        press(B_DN, 30);
        chk("down to 2", shown(), 2);
        p0 = pcnt;
        do_reset();
        chk("reset pulses", pcnt - p0, 0);
        chk("after reset", shown(), 0);

        // 3: down at zero, then saturate at max
        p0 = pcnt;
        press(B_DN, 30);
        chk("down at zero", shown(), 0);
        chk("down at zero pulses", pcnt - p0, 0);
        for (int i = 1; i <= 11; i++) begin
            press(B_UP, 30);
            if (i >= 10) chk($sformatf("sat press %0d", i), shown(), 10);
        end
        chk("sat pulses", pcnt - p0, 10);

        // 4: mute keeps the level
        p0 = pcnt;
        press(B_MU, 30);
        chk("mute display", shown(), 0);
        chk("mute mudo", int'(mudo), 1);
        chk("mute nivel", int'(nivel), 10);
        press(B_MU, 30);
        chk("unmute display", shown(), 10);
        chk("unmute mudo", int'(mudo), 0);
        press(B_MU, 30);
        press(B_UP, 30);
        chk("up clears mute", int'(mudo), 0);
        chk("up clears display", shown(), 10);
        chk("mute pulses", pcnt - p0, 4);

        // 5: simultaneous up/down, mute priority, mute at level zero
        p0 = pcnt;
        press(3'b011, 30);
        chk("up+down display", shown(), 10);
        chk("up+down pulses", pcnt - p0, 0);
        press(3'b110, 30);
        chk("mute wins mudo", int'(mudo), 1);
        chk("mute wins nivel", int'(nivel), 10);
        press(B_MU, 30);
        do_reset();
        p0 = pcnt;
        press(B_MU, 30);
        chk("mute at 0 mudo", int'(mudo), 1);
        press(B_MU, 30);
        chk("mute at 0 pulses", pcnt - p0, 0);

        // Button held through reset is ignored until released
        @(negedge clk);
        aumenta = 1'b1;
        repeat (60) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (90) @(negedge clk);
        chk("held through reset", shown(), 0);
        aumenta = 1'b0;
        repeat (6) @(negedge clk);
        chk("after held release", shown(), 0);

`ifdef AUTO_REPEAT_EN
        // 6: auto-repeat from zero
        do_reset();
        press(B_UP, 100);
        chk("auto repeat final", shown(), 4);
`endif

        // Second build: MAX_VOL=20, STEP=3, RESET_VOL=18
        @(negedge clk);
        chk("b2 reset display", shown2(), 18);
        chk("b2 reset nivel", int'(nivel2), 18);
        reset2 = 1'b0;
        press2(B_UP);
        chk("b2 up saturates", shown2(), 20);
        chk("b2 up pulse", pcnt2, 1);
        press2(B_UP);
        chk("b2 up at max", shown2(), 20);
        chk("b2 no pulse at max", pcnt2, 1);
        press2(B_DN);
        chk("b2 down", shown2(), 17);
        chk("b2 mudo", int'(mudo2), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
